// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV immediate decoder feeding a 2-entry elastic output buffer.
// Define IMM_GEN_PIPE_STATS_EN to add per-format transfer counters (stat_clear, stat_counts).
module imm_gen_pipe #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
`ifdef IMM_GEN_PIPE_STATS_EN
   input  logic             stat_clear,
   output logic [8*16-1:0]  stat_counts,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);
   localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3;
   localparam logic [2:0] F_U = 3'd4, F_J = 3'd5, F_SH = 3'd6, F_N = 3'd7;
   logic [6:0]      op;
   logic            sh;
   logic [XLEN-1:0] imm, imm_i, imm_s, imm_b, imm_u, imm_j, shamt, shamt_w;
   logic [2:0]      fmt;
   logic            ill;
   assign op      = in_instr[6:0];
   assign sh      = in_instr[13:12] == 2'b01;
   assign imm_i   = XLEN'($signed(in_instr[31:20]));
   assign imm_s   = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
   assign imm_b   = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
   assign imm_u   = XLEN'($signed({in_instr[31:12], 12'b0}));
   assign imm_j   = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
   assign shamt   = XLEN'(XLEN == 64 ? in_instr[25:20] : {1'b0, in_instr[24:20]});
   assign shamt_w = XLEN'(in_instr[24:20]);
   always_comb begin
      imm = '0;
      fmt = F_N;
      ill = 1'b1;
      case (op)
         7'b0010011: {imm, fmt, ill} = sh ? {shamt, F_SH, 1'b0} : {imm_i, F_I, 1'b0};
         7'b0000011,
         7'b1100111: {imm, fmt, ill} = {imm_i, F_I, 1'b0};
         7'b0011011: if (XLEN == 64) {imm, fmt, ill} = sh ? {shamt_w, F_SH, 1'b0} : {imm_i, F_I, 1'b0};
         7'b0100011: {imm, fmt, ill} = {imm_s, F_S, 1'b0};
         7'b1100011: {imm, fmt, ill} = {imm_b, F_B, 1'b0};
         7'b0110111,
         7'b0010111: {imm, fmt, ill} = {imm_u, F_U, 1'b0};
         7'b1101111: {imm, fmt, ill} = {imm_j, F_J, 1'b0};
         7'b0110011: {fmt, ill} = {F_R, 1'b0};
         7'b0111011: if (XLEN == 64) {fmt, ill} = {F_R, 1'b0};
         default: ;
      endcase
   end
   logic [XLEN-1:0]  b_imm [2];
   logic [2:0]       b_fmt [2];
   logic             b_ill [2];
   logic [TAG_W-1:0] b_tag [2];
   logic [1:0]       count;
   logic             head, tail, push, pop;
   // in_ready comes from registered count only, so no combinational path from out_ready
   assign in_ready    = count != 2'd2;
   assign out_valid   = count != 2'd0;
   assign push        = in_valid && in_ready;
   assign pop         = out_valid && out_ready;
   assign tail        = head ^ count[0];
   assign out_imm     = b_imm[head];
   assign out_fmt     = b_fmt[head];
   assign out_illegal = b_ill[head];
   assign out_tag     = b_tag[head];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         head  <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            b_imm[i] <= '0;
            b_fmt[i] <= '0;
            b_ill[i] <= 1'b0;
            b_tag[i] <= '0;
         end
      end else begin
         if (push) begin
            b_imm[tail] <= imm;
            b_fmt[tail] <= fmt;
            b_ill[tail] <= ill;
            b_tag[tail] <= in_tag;
         end
         if (pop) head <= ~head;
         count <= count + 2'(push) - 2'(pop);
      end
   end
`ifdef IMM_GEN_PIPE_STATS_EN
   logic [15:0] cnt [8];
   always_ff @(posedge clk or posedge rst) begin
      if (rst || stat_clear) begin
         for (int i = 0; i < 8; i++) cnt[i] <= '0;
      end else if (pop && cnt[out_fmt] != 16'hFFFF) begin
         cnt[out_fmt] <= cnt[out_fmt] + 16'd1;
      end
   end
   for (genvar k = 0; k < 8; k++) begin : g_stat
      assign stat_counts[16*k +: 16] = cnt[k];
   end
`endif
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: randomized and directed checks of imm_gen_pipe against a reference decoder.
// Stats checks are built when IMM_GEN_PIPE_STATS_EN is defined.
module tb_imm_gen_pipe;
   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
      logic [4:0]  tag;
   } ent_t;
   logic        clk = 1'b0, rst = 1'b1;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] in_instr = '0;
   logic [4:0]  in_tag = '0;
   logic        in_ready, out_valid, out_illegal;
   logic [63:0] out_imm;
   logic [2:0]  out_fmt;
   logic [4:0]  out_tag;
   logic        v32 = 1'b0, r32, ov32, oil32;
   logic [31:0] i32 = '0, oi32;
   logic [2:0]  of32;
   logic [4:0]  ot32;
   int          errors = 0, checks = 0;
   ent_t        sb[$];
   logic [4:0]  popped[$];
   logic [6:0]  ops [12] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F};
`ifdef IMM_GEN_PIPE_STATS_EN
   logic         stat_clear = 1'b0, clr = 1'b0;
   logic [127:0] stat_counts, sc32;
   int           sm [8];
`endif
   always #5 clk = ~clk;
   imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut (
      .clk(clk), .rst(rst),
`ifdef IMM_GEN_PIPE_STATS_EN
      .stat_clear(stat_clear), .stat_counts(stat_counts),
`endif
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
      .out_illegal(out_illegal), .out_tag(out_tag)
   );
   imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
      .clk(clk), .rst(rst),
`ifdef IMM_GEN_PIPE_STATS_EN
      .stat_clear(1'b0), .stat_counts(sc32),
`endif
      .in_valid(v32), .in_ready(r32), .in_instr(i32), .in_tag(5'd7),
      .out_valid(ov32), .out_ready(1'b1), .out_imm(oi32), .out_fmt(of32),
      .out_illegal(oil32), .out_tag(ot32)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // Reference decoder: immediates rebuilt from field weights with signed arithmetic
   function automatic ent_t model(input logic [31:0] i, input int xl, input logic [4:0] tg);
      ent_t r;
      longint si = longint'($signed(i));
      longint v = 0;
      logic [2:0] f = 3'd7;
      logic shift = i[14:12] == 3'd1 || i[14:12] == 3'd5;
      case (i[6:0])
         7'h13: begin
            f = shift ? 3'd6 : 3'd1;
            v = shift ? (xl == 64 ? longint'(i[25:20]) : longint'(i[24:20])) : si >>> 20;
         end
         7'h03, 7'h67: begin f = 3'd1; v = si >>> 20; end
         7'h1B: if (xl == 64) begin
            f = shift ? 3'd6 : 3'd1;
            v = shift ? longint'(i[24:20]) : si >>> 20;
         end
         7'h23: begin f = 3'd2; v = (si >>> 25) * 32 + longint'(i[11:7]); end
         7'h63: begin
            f = 3'd3;
            v = -longint'(i[31]) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
         end
         7'h37, 7'h17: begin f = 3'd4; v = (si >>> 12) * 4096; end
         7'h6F: begin
            f = 3'd5;
            v = -longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
         end
         7'h33: f = 3'd0;
         7'h3B: if (xl == 64) f = 3'd0;
         default: ;
      endcase
      r.imm = xl == 32 ? {32'b0, v[31:0]} : v;
      r.fmt = f;
      r.ill = f == 3'd7;
      r.tag = tg;
      return r;
   endfunction
   function automatic logic [31:0] rnd_instr();
      logic [31:0] i = $urandom;
      int k = $urandom_range(0, 12);
      if (k < 12) i[6:0] = ops[k];
      return i;
   endfunction
   // One clock: drive at negedge, sample 1ns later; the sampled handshakes commit at the next posedge
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [4:0] tg, input logic ordy);
      @(negedge clk);
      in_valid = v;
      in_instr = ins;
      in_tag = tg;
      out_ready = ordy;
`ifdef IMM_GEN_PIPE_STATS_EN
      stat_clear = clr;
`endif
      #1;
      check("in_ready", 64'(in_ready), 64'(sb.size() < 2));
      check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
`ifdef IMM_GEN_PIPE_STATS_EN
      for (int k = 0; k < 8; k++) check("stat_cnt", 64'(stat_counts[16*k +: 16]), 64'(sm[k]));
      if (stat_clear) for (int k = 0; k < 8; k++) sm[k] = 0;
      else if (out_valid && out_ready && sb.size() != 0 && sm[sb[0].fmt] < 65535) sm[sb[0].fmt]++;
`endif
      if (out_valid && sb.size() != 0) begin
         check("imm", out_imm, sb[0].imm);
         check("fmt", 64'(out_fmt), 64'(sb[0].fmt));
         check("illegal", 64'(out_illegal), 64'(sb[0].ill));
         check("tag", 64'(out_tag), 64'(sb[0].tag));
         if (out_ready) begin
            popped.push_back(sb[0].tag);
            void'(sb.pop_front());
         end
      end
      if (in_valid && in_ready) sb.push_back(model(in_instr, 64, in_tag));
   endtask
   task automatic dir(input logic [31:0] ins, input logic [63:0] imm, input logic [2:0] fmt, input logic [4:0] tg);
      cycle(1'b1, ins, tg, 1'b1);
      cycle(1'b0, 32'h0, 5'd0, 1'b1);
      check("dir_valid", 64'(out_valid), 64'd1);
      check("dir_imm", out_imm, imm);
      check("dir_fmt", 64'(out_fmt), 64'(fmt));
      check("dir_tag", 64'(out_tag), 64'(tg));
   endtask
   task automatic t32(input logic [31:0] ins);
      ent_t e = model(ins, 32, 5'd7);
      @(negedge clk);
      v32 = 1'b1;
      i32 = ins;
      @(negedge clk);
      v32 = 1'b0;
      #1;
      check("x32_valid", 64'(ov32), 64'd1);
      check("x32_imm", {32'b0, oi32}, e.imm);
      check("x32_fmt", 64'(of32), 64'(e.fmt));
      check("x32_illegal", 64'(oil32), 64'(e.ill));
      check("x32_tag", 64'(ot32), 64'd7);
   endtask
   initial begin
`ifdef IMM_GEN_PIPE_STATS_EN
      for (int k = 0; k < 8; k++) sm[k] = 0;
`endif
      repeat (2) @(negedge clk);
      #1;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd1);
      check("rst_imm", out_imm, 64'd0);
      check("rst_fmt", 64'(out_fmt), 64'd0);
      check("rst_illegal", 64'(out_illegal), 64'd0);
      check("rst_tag", 64'(out_tag), 64'd0);
      rst = 1'b0;
      dir(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 5'd9);
      dir(32'hFE113C23, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 5'd10);
      dir(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 5'd11);
      dir(32'h123452B7, 64'h0000_0000_1234_5000, 3'd4, 5'd12);
      dir(32'h001000EF, 64'h800, 3'd5, 5'd13);
      dir(32'h43F0D093, 64'h3F, 3'd6, 5'd14);
      dir(32'h0000007F, 64'h0, 3'd7, 5'd15);
      check("ill_flag", 64'(out_illegal), 64'd1);
      // Backpressure: third instruction waits until a slot frees
      popped.delete();
      cycle(1'b1, 32'hFFF00093, 5'd1, 1'b0);
      cycle(1'b1, 32'hFE113C23, 5'd2, 1'b0);
      cycle(1'b1, 32'h001000EF, 5'd3, 1'b0);
      check("full_ready", 64'(in_ready), 64'd0);
      cycle(1'b1, 32'h001000EF, 5'd3, 1'b0);
      cycle(1'b1, 32'h001000EF, 5'd3, 1'b1);
      cycle(1'b1, 32'h001000EF, 5'd3, 1'b1);
      repeat (4) cycle(1'b0, 32'h0, 5'd0, 1'b1);
      check("order_cnt", 64'(popped.size()), 64'd3);
      if (popped.size() == 3) check("order", {popped[0], popped[1], popped[2]}, {5'd1, 5'd2, 5'd3});
      // Asynchronous reset with a full buffer
      cycle(1'b1, 32'hFE000EE3, 5'd4, 1'b0);
      cycle(1'b1, 32'h123452B7, 5'd5, 1'b0);
      cycle(1'b0, 32'h0, 5'd0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_ready", 64'(in_ready), 64'd1);
      check("arst_tag", 64'(out_tag), 64'd0);
      check("arst_imm", out_imm, 64'd0);
      sb.delete();
`ifdef IMM_GEN_PIPE_STATS_EN
      for (int k = 0; k < 8; k++) sm[k] = 0;
`endif
      @(negedge clk);
      rst = 1'b0;
      repeat (3) cycle(1'b0, 32'h0, 5'd0, 1'b1);
      dir(32'h00500113, 64'h5, 3'd1, 5'd6);
      repeat (400) cycle(1'($urandom_range(0, 3) != 0), rnd_instr(), 5'($urandom), 1'($urandom_range(0, 2) != 0));
      repeat (4) cycle(1'b0, 32'h0, 5'd0, 1'b1);
      t32(32'h0000001B);
      t32(32'h0000003B);
      t32(32'h41F0D093);
      t32(32'h123452B7);
      t32(32'hFE000EE3);
      repeat (40) t32(rnd_instr());
`ifdef IMM_GEN_PIPE_STATS_EN
      clr = 1'b1;
      cycle(1'b0, 32'h0, 5'd0, 1'b1);
      clr = 1'b0;
      repeat (3) cycle(1'b1, 32'hFFF00093, 5'd1, 1'b1);
      cycle(1'b1, 32'hFE000EE3, 5'd2, 1'b1);
      repeat (3) cycle(1'b0, 32'h0, 5'd0, 1'b1);
      check("stat_i", 64'(stat_counts[31:16]), 64'd3);
      check("stat_b", 64'(stat_counts[63:48]), 64'd1);
      cycle(1'b1, 32'hFFF00093, 5'd1, 1'b1);
      clr = 1'b1;
      cycle(1'b0, 32'h0, 5'd0, 1'b1);
      clr = 1'b0;
      cycle(1'b0, 32'h0, 5'd0, 1'b1);
      check("stat_clr", stat_counts[63:0] | stat_counts[127:64], 64'd0);
      repeat (65540) cycle(1'b1, 32'h00000013, 5'd0, 1'b1);
      repeat (3) cycle(1'b0, 32'h0, 5'd0, 1'b1);
      check("stat_sat", 64'(stat_counts[31:16]), 64'hFFFF);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage. It accepts 32-bit RV instructions over a valid/ready handshake and decodes every base format: I, S, B, U, J, shift-immediate, and R (no immediate). It sign-extends the immediate to XLEN and returns it with a format code, an illegal flag and a pass-through tag. A 2-entry elastic output buffer absorbs backpressure from execute without dropping or reordering instructions.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
TAG_W, 5, width of the opaque tag carried alongside each instruction (e.g. ROB or PC index).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  in_instr/in_tag valid.
in_ready  output  1  block can accept; transfer when in_valid && in_ready.
in_instr  input  32  raw instruction.
in_tag  input  TAG_W  tag, returned unchanged.
out_valid  output  1  output entry valid.
out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
out_imm  output  XLEN  decoded immediate.
out_fmt  output  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT, 7=NONE/illegal.
out_illegal  output  1  opcode not recognised.
out_tag  output  TAG_W  tag of the entry on out_imm.

Behaviour:
- Decode is combinational on in_instr. The result is written into the buffer on the accept edge.
- Decode by opcode[6:0]:
  - 0010011 (OP-IMM), 0000011 (LOAD), 1100111 (JALR): I, sext(instr[31:20]).
  - OP-IMM with funct3 001/101: SHAMT, zero-extended instr[25:20] when XLEN=64, instr[24:20] when XLEN=32. funct7 bits are never part of the immediate.
  - 0011011 (OP-IMM-32): I/SHAMT as above, using instr[24:20] for shifts. Legal only when XLEN=64; otherwise illegal.
  - 0100011: S, sext({instr[31:25], instr[11:7]}).
  - 1100011: B, sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 0110111, 0010111: U, sext({instr[31:12], 12'b0}). For XLEN=32 there is no extension.
  - 1101111: J, sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 0110011, 0111011 (0111011 only when XLEN=64): R, imm=0, illegal=0.
  - Anything else: fmt=7, imm=0, illegal=1. The entry is still passed through in order.
- Buffer: 2-entry FIFO with a registered count (0..2). Outputs are driven from the head entry.
  - in_ready = (count < 2); it depends only on registered state, never combinationally on out_ready.
  - out_valid = (count != 0).
  - Latency: 1 cycle. An instruction accepted at edge N is presented on the outputs after edge N when the buffer was empty.
  - Push and pop in the same cycle: count unchanged, head advances, new entry goes to the tail.
  - count=2: in_ready=0, so no push even if out_ready=1 that cycle. in_ready rises the cycle after the pop.
  - count=0: out_valid=0; out_imm/out_fmt/out_tag hold their last value (don't-care).
  - Output fields are stable while out_valid && !out_ready.
- Reset, at any time including mid-transfer: count=0, out_valid=0, in_ready=1 once rst deasserts, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0. Buffered entries are discarded.

Optional Feature:
IMM_GEN_PIPE_STATS_EN
- Defined:
  - Adds input stat_clear (1) and output stat_counts (8*16).
  - stat_counts holds one 16-bit saturating counter per out_fmt code. Counter k occupies bits [16k+15:16k].
  - A counter increments on each output transfer (out_valid && out_ready) whose fmt is k. It saturates at 0xFFFF.
  - stat_clear synchronously zeroes all counters and has priority over an increment in the same cycle.
  - rst zeroes all counters.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
- XLEN=64, out_ready=1, push 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, out_imm=0xFFFFFFFFFFFFFFFF, fmt=1, tag echoed.
- Push in turn: 0xFE113C23 (sd -8), 0xFE000EE3 (beq -4), 0x123452B7 (lui), 0x001000EF (jal 2048), 0x43F0D093 (srai 63).
  - Expect imm 0xFFFFFFFFFFFFFFF8 (S), 0xFFFFFFFFFFFFFFFC (B), 0x0000000012345000 (U), 0x800 (J), 0x3F (SHAMT, not 0x43F).
- out_ready=0, push 3 instructions (tags 1, 2, 3) -> in_ready=0 after 2 accepted, tag 3 held. Raise out_ready -> outputs tags 1, 2, 3 in order with no duplication; fields stable while stalled.
- Push 0x0000007F -> fmt=7, illegal=1, imm=0. With XLEN=32, push 0x0000001B -> illegal=1.
- Fill buffer with 2 entries, assert rst mid-cycle -> out_valid=0 immediately (async), in_ready=1 after release, no stale entries emerge.
- STATS_EN: 3 I-type and 1 B-type transfers -> counter 1 = 3, counter 3 = 1. Assert stat_clear in the same cycle as a transfer -> all counters 0. Preload a counter to 0xFFFF -> it stays at 0xFFFF.
